complete_unit: RTL and testbench
================================

Name: complete_unit

Overview:
- Completion-side transmitter feeding the reorder buffer: collects results from NUM_SRC functional units and broadcasts up to NUM_LANES completions per cycle.
- Each completion carries PC, dest reg and data; the ROB matches on PC, marks the entry complete and stores the data.
- Sits between the FU outputs and the ROB completion ports.
- Per-source FIFOs absorb bursts; a round-robin arbiter packs heads onto lanes; a ROB-side ready provides backpressure.

Parameters:
- NUM_SRC, 4, number of functional-unit result sources.
- NUM_LANES, 2, completion lanes driven to the ROB per cycle (NUM_LANES <= NUM_SRC).
- FIFO_DEPTH, 4, entries per source FIFO (power of two, >= 2).
- PREG_W, 6, physical dest reg width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  synchronous active-low reset.
- flush  in  1  synchronous clear of all buffered and outgoing completions.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source FIFO not full (combinational from count).
- src_pc  in  NUM_SRC*32  flattened, source i at [32i+31:32i].
- src_dest  in  NUM_SRC*PREG_W  flattened dest regs.
- src_data  in  NUM_SRC*32  flattened result data.
- rob_ready  in  1  ROB accepts this cycle's lanes.
- cmp_valid  out  NUM_LANES  lane valid.
- cmp_pc  out  NUM_LANES*32  lane PC.
- cmp_dest  out  NUM_LANES*PREG_W  lane dest reg.
- cmp_data  out  NUM_LANES*32  lane data.

Behaviour:
- Reset (rstn=0 at edge): FIFOs empty, pointers 0, rr_ptr=0, all cmp_* = 0, src_ready all 1 one cycle after reset; reset wins over flush and every other input.
- Push: src_valid[i] & src_ready[i] at an edge writes {pc,dest,data} to FIFO i. When full, src_ready[i]=0 and src_valid is ignored; the FU must hold its result.
- Output regs: load enable = rob_ready | ~(|cmp_valid). When disabled, all cmp_* hold and no FIFO pops.
- Arbitration (when load enabled): scan sources from rr_ptr upward with wrap; the first NUM_LANES non-empty FIFOs are granted, assigned to lanes 0,1,... in scan order; remaining lanes get cmp_valid=0 with pc/dest/data = 0. Each granted FIFO pops exactly one entry.
- rr_ptr updates to (last granted index + 1) mod NUM_SRC; unchanged if no grant.
- Latency: push at edge t, FIFO head at edge t+1 loaded into cmp_* (visible cycle t+1..t+2). Minimum 1 cycle in FIFO.
- Simultaneous push and pop on the same FIFO at the same edge is legal, including when full (ready reflects pre-pop count, so no push when full).
- Ordering: per-source FIFO order preserved; no ordering guarantee across sources (the ROB matches by PC).
- flush=1 at edge: FIFOs emptied, cmp_valid cleared, rr_ptr kept; pushes in the same cycle are discarded.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits with an extra count register of log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: COMPLETE_BYPASS_EN.
- Defined: a source whose FIFO is empty and that is granted in the same cycle as its push goes straight from src_* into cmp_* (1-edge latency) without writing the FIFO; the grant scan treats src_valid as non-empty for empty FIFOs.
- Undefined: every result passes through its FIFO (2-edge latency). Ports are identical in both builds.

Decomposition:
- Shared package cpu_pkg: PREG_W, XLEN=32, completion record typedef {pc, dest, data}, default NUM_SRC/NUM_LANES.
- One sub-module: cmp_fifo (single-source sync FIFO with full/empty/count; push, pop, flush, synchronous active-low rstn). The arbiter stays in complete_unit.

Test Plan:
- Single result: src0 pushes pc=0x100, dest=5, data=0xAB with rob_ready=1 -> two edges later cmp_valid=01, cmp_pc lane0=0x100, dest 5, data 0xAB; one edge with bypass.
- All four sources push in one cycle (pcs 0x10,0x20,0x30,0x40), rr_ptr=0 -> cycle A lanes {0x10,0x20}, cycle B {0x30,0x40}; rr_ptr ends at 0.
- Backpressure: rob_ready=0 with lanes valid -> cmp_* held 3 cycles unchanged; src0 pushes 5 results -> src_ready[0]=0 after 4; rob_ready=1 drains in FIFO order.
- Fairness: src0 and src3 continuously valid, NUM_LANES=1 -> grants alternate 0,3,0,3.
- Flush with FIFOs holding 3 entries and a push the same edge -> next cycle cmp_valid=0, all src_ready=1, no stale completion ever emitted.
- Reset asserted mid-burst alongside flush -> all cmp_* = 0 and FIFOs empty after the edge; first post-reset push completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, completion record type and default sizing
// for the completion unit.
package cpu_pkg;
    localparam int XLEN          = 32;
    localparam int PREG_W        = 6;
    localparam int DEF_NUM_SRC   = 4;
    localparam int DEF_NUM_LANES = 2;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [PREG_W-1:0] dest;
        logic [XLEN-1:0]   data;
    } cmp_rec_t;
endpackage

// File: rtl/cmp_fifo.sv
// Single-source synchronous FIFO holding completion records, with empty flag
// and occupancy count; flush and active-low reset clear it synchronously.
module cmp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 70
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full = (r_cnt == (AW+1)'(DEPTH));
    assign empty  = (r_cnt == '0);
    assign count  = r_cnt;
    assign rdata  = r_mem[r_rd];
    assign w_push = push & ~w_full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // A write that coincides with flush/reset lands in a slot the pointers no longer cover.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= wdata;
    end
endmodule

// File: rtl/complete_unit.sv
// Completion transmitter: per-source FIFOs, round-robin packing onto ROB lanes.
// Optional same-cycle bypass of empty FIFOs when COMPLETE_BYPASS_EN is defined.
module complete_unit
    import cpu_pkg::*;
#(
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int NUM_LANES  = DEF_NUM_LANES,
    parameter int FIFO_DEPTH = 4,
    parameter int PREG_W     = cpu_pkg::PREG_W
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*XLEN-1:0]     src_pc,
    input  logic [NUM_SRC*PREG_W-1:0]   src_dest,
    input  logic [NUM_SRC*XLEN-1:0]     src_data,
    input  logic                        rob_ready,
    output logic [NUM_LANES-1:0]        cmp_valid,
    output logic [NUM_LANES*XLEN-1:0]   cmp_pc,
    output logic [NUM_LANES*PREG_W-1:0] cmp_dest,
    output logic [NUM_LANES*XLEN-1:0]   cmp_data
);
    localparam int REC_W = 2*XLEN + PREG_W;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [REC_W-1:0]            w_src_rec [NUM_SRC];
    logic [REC_W-1:0]            w_head    [NUM_SRC];
    logic [CW-1:0]               w_cnt     [NUM_SRC];
    logic [NUM_SRC-1:0]          w_empty;
    logic [NUM_SRC-1:0]          w_grant;
    logic [NUM_SRC-1:0]          w_byp;
    logic                        w_load;
    logic                        w_any;
    logic [RR_W-1:0]             w_next_rr;
    logic [NUM_LANES-1:0]        w_nxt_valid;
    logic [NUM_LANES*XLEN-1:0]   w_nxt_pc;
    logic [NUM_LANES*PREG_W-1:0] w_nxt_dest;
    logic [NUM_LANES*XLEN-1:0]   w_nxt_data;

    logic [RR_W-1:0]             r_rr;
    logic [NUM_LANES-1:0]        r_cmp_valid;
    logic [NUM_LANES*XLEN-1:0]   r_cmp_pc;
    logic [NUM_LANES*PREG_W-1:0] r_cmp_dest;
    logic [NUM_LANES*XLEN-1:0]   r_cmp_data;

    assign w_load = rob_ready | ~(|r_cmp_valid);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign w_src_rec[i] = {src_pc[XLEN*i +: XLEN], src_dest[PREG_W*i +: PREG_W],
                               src_data[XLEN*i +: XLEN]};
        assign src_ready[i] = (w_cnt[i] != CW'(FIFO_DEPTH));

        cmp_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (REC_W)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .flush (flush),
            .push  (src_valid[i] & src_ready[i] & ~w_byp[i]),
            .pop   (w_grant[i]),
            .wdata (w_src_rec[i]),
            .rdata (w_head[i]),
            .empty (w_empty[i]),
            .count (w_cnt[i])
        );
    end

    // Round-robin scan from r_rr; granted sources fill lanes in scan order.
    always_comb begin
        int               n;
        int               idx;
        int               last;
        logic             w_take;
        logic [REC_W-1:0] w_rec;
        n           = 0;
        idx         = 0;
        last        = 0;
        w_take      = 1'b0;
        w_rec       = '0;
        w_grant     = '0;
        w_byp       = '0;
        w_any       = 1'b0;
        w_nxt_valid = '0;
        w_nxt_pc    = '0;
        w_nxt_dest  = '0;
        w_nxt_data  = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            w_take = ~w_empty[idx];
`ifdef COMPLETE_BYPASS_EN
            w_take = w_take | src_valid[idx];
`endif
            if (w_load && n < NUM_LANES && w_take) begin
                if (w_empty[idx]) begin
                    w_byp[idx] = 1'b1;
                    w_rec      = w_src_rec[idx];
                end else begin
                    w_grant[idx] = 1'b1;
                    w_rec        = w_head[idx];
                end
                w_nxt_valid[n]                = 1'b1;
                w_nxt_pc[XLEN*n +: XLEN]      = w_rec[REC_W-1 -: XLEN];
                w_nxt_dest[PREG_W*n +: PREG_W] = w_rec[XLEN +: PREG_W];
                w_nxt_data[XLEN*n +: XLEN]    = w_rec[XLEN-1:0];
                n     = n + 1;
                last  = idx;
                w_any = 1'b1;
            end
        end
        w_next_rr = (last + 1 >= NUM_SRC) ? '0 : RR_W'(last + 1);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rr        <= '0;
            r_cmp_valid <= '0;
            r_cmp_pc    <= '0;
            r_cmp_dest  <= '0;
            r_cmp_data  <= '0;
        end else if (flush) begin
            r_cmp_valid <= '0;
            r_cmp_pc    <= '0;
            r_cmp_dest  <= '0;
            r_cmp_data  <= '0;
        end else if (w_load) begin
            r_cmp_valid <= w_nxt_valid;
            r_cmp_pc    <= w_nxt_pc;
            r_cmp_dest  <= w_nxt_dest;
            r_cmp_data  <= w_nxt_data;
            if (w_any) r_rr <= w_next_rr;
        end
    end

    assign cmp_valid = r_cmp_valid;
    assign cmp_pc    = r_cmp_pc;
    assign cmp_dest  = r_cmp_dest;
    assign cmp_data  = r_cmp_data;
endmodule

// File: tb/tb_complete_unit.sv
// Bench for complete_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_complete_unit;
    localparam int NS = 4;
    localparam int NL = 2;
    localparam int D  = 4;
    localparam int PW = 6;
    localparam int RW = 64 + PW;

    logic              clk = 1'b0;
    logic              rstn;
    logic              flush;
    logic              rob_ready;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*32-1:0]  src_pc;
    logic [NS*PW-1:0]  src_dest;
    logic [NS*32-1:0]  src_data;
    logic [NL-1:0]     cmp_valid;
    logic [NL*32-1:0]  cmp_pc;
    logic [NL*PW-1:0]  cmp_dest;
    logic [NL*32-1:0]  cmp_data;

    complete_unit #(.NUM_SRC(NS), .NUM_LANES(NL), .FIFO_DEPTH(D), .PREG_W(PW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .src_valid(src_valid), .src_ready(src_ready),
        .src_pc(src_pc), .src_dest(src_dest), .src_data(src_data),
        .rob_ready(rob_ready),
        .cmp_valid(cmp_valid), .cmp_pc(cmp_pc), .cmp_dest(cmp_dest), .cmp_data(cmp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model: per-source queues, lane registers, round-robin pointer.
    logic [RW-1:0] mq [NS][$];
    logic [RW-1:0] ml [NL];
    logic [NL-1:0] mv = '0;
    int            rr = 0;
    bit            mpush [NS];
    bit            started = 0;

    function automatic logic [RW-1:0] srec(input int i);
        return {src_pc[32*i +: 32], src_dest[PW*i +: PW], src_data[32*i +: 32]};
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (!rstn) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            rr = 0;
            mv = '0;
        end else if (flush) begin
            for (int i = 0; i < NS; i++) mq[i].delete();
            mv = '0;
        end else begin
            for (int i = 0; i < NS; i++) mpush[i] = src_valid[i] && (mq[i].size() < D);
            if (rob_ready || mv == '0) begin
                int n;
                int last;
                n = 0;
                last = -1;
                mv = '0;
                for (int k = 0; k < NS; k++) begin
                    int i;
                    i = (rr + k) % NS;
                    if (n < NL) begin
                        if (mq[i].size() > 0) begin
                            ml[n] = mq[i].pop_front();
                            mv[n] = 1'b1;
                            n++;
                            last = i;
                        end
`ifdef COMPLETE_BYPASS_EN
                        else if (mpush[i]) begin
                            ml[n] = srec(i);
                            mpush[i] = 0;
                            mv[n] = 1'b1;
                            n++;
                            last = i;
                        end
`endif
                    end
                end
                if (last >= 0) rr = (last + 1) % NS;
            end
            for (int i = 0; i < NS; i++) if (mpush[i]) mq[i].push_back(srec(i));
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic [NS-1:0] erdy;
            chk("cmp_valid", cmp_valid, mv);
            for (int l = 0; l < NL; l++) begin
                if (mv[l]) begin
                    chk("lane_pc", cmp_pc[32*l +: 32], ml[l][RW-1 -: 32]);
                    chk("lane_dest", cmp_dest[PW*l +: PW], ml[l][32 +: PW]);
                    chk("lane_data", cmp_data[32*l +: 32], ml[l][31:0]);
                end
            end
            for (int i = 0; i < NS; i++) erdy[i] = (mq[i].size() < D);
            chk("src_ready", src_ready, erdy);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] pc, input logic [PW-1:0] dst,
                           input logic [31:0] dat);
        src_valid[i]          = 1'b1;
        src_pc[32*i +: 32]    = pc;
        src_dest[PW*i +: PW]  = dst;
        src_data[32*i +: 32]  = dat;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < NS; i++) begin
            src_valid[i]         = ($urandom_range(0, 99) < 45);
            src_pc[32*i +: 32]   = $urandom;
            src_dest[PW*i +: PW] = PW'($urandom);
            src_data[32*i +: 32] = $urandom;
        end
        rob_ready = ($urandom_range(0, 99) < 65);
        flush     = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; rob_ready = 1'b1;
        src_valid = '0; src_pc = '0; src_dest = '0; src_data = '0;
        tick(); tick();
        chk("rst_valid", cmp_valid, 2'b00);
        chk("rst_pc", cmp_pc, 64'h0);
        chk("rst_ready", src_ready, 4'hF);
        rstn = 1'b1;

        // single result
        set_src(0, 32'h100, 6'd5, 32'hAB);
        tick();
        src_valid = '0;
`ifndef COMPLETE_BYPASS_EN
        tick();
`endif
        chk("single_valid", cmp_valid, 2'b01);
        chk("single_pc", cmp_pc[31:0], 32'h100);
        chk("single_dest", cmp_dest[PW-1:0], 6'd5);
        chk("single_data", cmp_data[31:0], 32'hAB);
        repeat (3) tick();

        // four sources at once from rr_ptr = 0
        rstn = 1'b0; tick(); rstn = 1'b1;
        for (int i = 0; i < NS; i++) set_src(i, 32'(16 * (i + 1)), PW'(i), 32'(i));
        tick();
        src_valid = '0;
`ifndef COMPLETE_BYPASS_EN
        tick();
`endif
        chk("burst_a_valid", cmp_valid, 2'b11);
        chk("burst_a_pc", cmp_pc, {32'h20, 32'h10});
        tick();
        chk("burst_b_pc", cmp_pc, {32'h40, 32'h30});
        tick(); tick();

        // backpressure
        rob_ready = 1'b0;
        set_src(1, 32'h600, 6'd1, 32'h66);
        tick();
        src_valid = '0;
        tick(); tick();
        chk("bp_load_pc", cmp_pc[31:0], 32'h600);
        for (int j = 0; j < 4; j++) begin
            set_src(0, 32'h500 + 32'(j), PW'(j), 32'h50 + 32'(j));
            tick();
        end
        chk("bp_full", src_ready[0], 1'b0);
        chk("bp_hold_pc", cmp_pc[31:0], 32'h600);
        chk("bp_hold_valid", cmp_valid, 2'b01);
        set_src(0, 32'h504, 6'd4, 32'h54);
        tick();
        chk("bp_still_full", src_ready[0], 1'b0);
        src_valid = '0;
        rob_ready = 1'b1;
        tick();
        chk("drain0_pc", cmp_pc[31:0], 32'h500);
        tick();
        chk("drain1_pc", cmp_pc[31:0], 32'h501);
        repeat (4) tick();

        // flush with buffered entries and a concurrent push
        rstn = 1'b0; tick(); rstn = 1'b1;
        rob_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            set_src(2, 32'h700 + 32'(j), PW'(j), 32'h70 + 32'(j));
            tick();
        end
        src_valid = '0;
        set_src(3, 32'h7FF, 6'd7, 32'h77);
        flush = 1'b1;
        tick();
        chk("flush_valid", cmp_valid, 2'b00);
        chk("flush_ready", src_ready, 4'hF);
        flush = 1'b0; src_valid = '0; rob_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("no_stale", cmp_valid, 2'b00);
        end

        // reset together with flush in the middle of traffic
        for (int j = 0; j < 10; j++) begin
            rand_inputs();
            flush = 1'b0;
            tick();
        end
        rstn = 1'b0; flush = 1'b1;
        tick();
        chk("rst_mid_valid", cmp_valid, 2'b00);
        chk("rst_mid_pc", cmp_pc, 64'h0);
        chk("rst_mid_data", cmp_data, 64'h0);
        chk("rst_mid_ready", src_ready, 4'hF);
        rstn = 1'b1; flush = 1'b0; src_valid = '0; rob_ready = 1'b1;
        set_src(3, 32'h900, 6'd9, 32'h99);
        tick();
        src_valid = '0;
`ifndef COMPLETE_BYPASS_EN
        tick();
`endif
        chk("post_rst_valid", cmp_valid, 2'b01);
        chk("post_rst_pc", cmp_pc[31:0], 32'h900);

        // randomized traffic
        for (int j = 0; j < 3000; j++) begin
            rand_inputs();
            tick();
        end
        src_valid = '0; flush = 1'b0; rob_ready = 1'b1;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
